// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage:
// funct3 access sizes, writeback selects and FSM states.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC4 = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

endpackage

// File: rtl/dmem_be.sv
// Data RAM: byte-enable synchronous write,
// combinational read on the same word address.
module dmem_be #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [3:0]               be_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_ws.sv
// Memory-access stage with configurable wait states
// and the MEM/WB pipeline register.
module mem_stage_ws
    import mem_stage_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int RD_W        = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_m,
    input  logic            reg_write_m,
    input  logic [1:0]      result_src_m,
    input  logic            mem_read_m,
    input  logic            mem_write_m,
    input  logic [2:0]      funct3_m,
    input  logic [31:0]     alu_result_m,
    input  logic [31:0]     write_data_m,
    input  logic [RD_W-1:0] rd_m,
    input  logic [31:0]     pc_plus4_m,
    output logic            stall_m,
    output logic            valid_w,
    output logic            reg_write_w,
    output logic [1:0]      result_src_w,
    output logic [31:0]     read_data_w,
    output logic [31:0]     alu_result_w,
    output logic [31:0]     pc_plus4_w,
    output logic [RD_W-1:0] rd_w,
    output logic            fault_w
);

    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        stall;

    logic        access, is_store, is_load;
    logic [1:0]  off;
    logic        f3_ok, misal, fault, rw_ok;
    logic [3:0]  be, we_be;
    logic [31:0] wdat, rdata, ld_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    logic            valid_q, rw_q, fault_q;
    logic [1:0]      rs_q;
    logic [31:0]     rdat_q, alu_q, pc4_q;
    logic [RD_W-1:0] rd_q;

    // Both strobes high is a store: the write wins.
    assign access   = valid_m & (mem_read_m | mem_write_m);
    assign is_store = mem_write_m;
    assign is_load  = mem_read_m & ~mem_write_m;
    assign off      = alu_result_m[1:0];

    always_comb begin
        f3_ok = 1'b0;
        misal = 1'b0;
        case (funct3_m)
            F3_B:  f3_ok = 1'b1;
            F3_H: begin
                f3_ok = 1'b1;
                misal = off[0];
            end
            F3_W: begin
                f3_ok = 1'b1;
                misal = off != 2'b00;
            end
            F3_BU: f3_ok = is_load;
            F3_HU: begin
                f3_ok = is_load;
                misal = off[0];
            end
            default: f3_ok = 1'b0;
        endcase
    end

    assign fault = access & (~f3_ok | misal);

    always_comb begin
        be   = 4'b0000;
        wdat = write_data_m;
        case (funct3_m)
            F3_B: begin
                be   = 4'b0001 << off;
                wdat = {4{write_data_m[7:0]}};
            end
            F3_H: begin
                be   = off[1] ? 4'b1100 : 4'b0011;
                wdat = {2{write_data_m[15:0]}};
            end
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (access && WS != 4'd0) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'd1;
                    stall   = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == WS) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
        endcase
    end

    // Reset must silence the stall and any pending commit at once.
    assign stall_m = stall & rst;
    assign we_be   = (access & is_store & ~fault & ~stall & rst)
                   ? be : 4'b0000;

    dmem_be #(
        .DEPTH(DEPTH)
    ) u_dmem (
        .clk    (clk),
        .be_i   (we_be),
        .addr_i (alu_result_m[2 +: AW]),
        .wdata_i(wdat),
        .rdata_o(rdata)
    );

    assign byte_sel = rdata[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_data = 32'd0;
        case (funct3_m)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    ld_data = rdata;
            F3_BU:   ld_data = {24'd0, byte_sel};
            F3_HU:   ld_data = {16'd0, half_sel};
            default: ld_data = 32'd0;
        endcase
    end

    assign rw_ok = valid_m & reg_write_m
                 & ~(access & (is_store | fault));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            fault_q <= 1'b0;
            rs_q    <= 2'b00;
            rdat_q  <= 32'd0;
            alu_q   <= 32'd0;
            pc4_q   <= 32'd0;
            rd_q    <= '0;
        end else if (stall) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= valid_m;
            rw_q    <= rw_ok;
            fault_q <= fault;
            rs_q    <= result_src_m;
            rdat_q  <= (access & is_load & ~fault)
                     ? ld_data : 32'd0;
            alu_q   <= alu_result_m;
            pc4_q   <= pc_plus4_m;
            rd_q    <= rd_m;
        end
    end

    assign valid_w      = valid_q;
    assign reg_write_w  = rw_q;
    assign fault_w      = fault_q;
    assign result_src_w = rs_q;
    assign read_data_w  = rdat_q;
    assign alu_result_w = alu_q;
    assign pc_plus4_w   = pc4_q;
    assign rd_w         = rd_q;

endmodule

// File: tb/tb_mem_stage_ws.sv
// Directed bench: a zero-wait and a three-wait instance
// share stimulus; each phase checks one of them.
module tb_mem_stage_ws;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_m = 1'b0;
    logic        reg_write_m = 1'b0;
    logic [1:0]  result_src_m = 2'b00;
    logic        mem_read_m = 1'b0;
    logic        mem_write_m = 1'b0;
    logic [2:0]  funct3_m = 3'b000;
    logic [31:0] alu_result_m = 32'd0;
    logic [31:0] write_data_m = 32'd0;
    logic [4:0]  rd_m = 5'd0;
    logic [31:0] pc_plus4_m = 32'd0;

    logic        s0, v0, rw0, f0;
    logic [1:0]  rs0;
    logic [31:0] rdat0, alu0, pc0;
    logic [4:0]  rdw0;

    logic        s3, v3, rw3, f3w;
    logic [1:0]  rs3;
    logic [31:0] rdat3, alu3, pc3;
    logic [4:0]  rdw3;

    int errs = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    mem_stage_ws #(.DEPTH(16), .WAIT_STATES(0), .RD_W(5)) u0 (
        .clk(clk), .rst(rst), .valid_m(valid_m),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .funct3_m(funct3_m), .alu_result_m(alu_result_m),
        .write_data_m(write_data_m), .rd_m(rd_m),
        .pc_plus4_m(pc_plus4_m), .stall_m(s0), .valid_w(v0),
        .reg_write_w(rw0), .result_src_w(rs0),
        .read_data_w(rdat0), .alu_result_w(alu0),
        .pc_plus4_w(pc0), .rd_w(rdw0), .fault_w(f0)
    );

    mem_stage_ws #(.DEPTH(16), .WAIT_STATES(3), .RD_W(5)) u3 (
        .clk(clk), .rst(rst), .valid_m(valid_m),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .funct3_m(funct3_m), .alu_result_m(alu_result_m),
        .write_data_m(write_data_m), .rd_m(rd_m),
        .pc_plus4_m(pc_plus4_m), .stall_m(s3), .valid_w(v3),
        .reg_write_w(rw3), .result_src_w(rs3),
        .read_data_w(rdat3), .alu_result_w(alu3),
        .pc_plus4_w(pc3), .rd_w(rdw3), .fault_w(f3w)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic ld, input logic st,
                      input logic [2:0] f3,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [4:0] rd);
        valid_m      = 1'b1;
        mem_read_m   = ld;
        mem_write_m  = st;
        funct3_m     = f3;
        alu_result_m = a;
        write_data_m = wd;
        rd_m         = rd;
        reg_write_m  = ld & ~st;
        result_src_m = ld ? 2'b01 : 2'b00;
        pc_plus4_m   = 32'h1000 + a;
    endtask

    task automatic idle();
        valid_m     = 1'b0;
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
        reg_write_m = 1'b0;
    endtask

    task automatic st0(input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd);
        op(1'b0, 1'b1, f3, a, wd, 5'd0);
        tick();
    endtask

    task automatic ld0(input string tag,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] exp);
        op(1'b1, 1'b0, f3, a, 32'd0, 5'd5);
        #1;
        chk({tag, " stall"}, 32'(s0), 32'd0);
        tick();
        chk(tag, rdat0, exp);
    endtask

    task automatic wait3(input string tag);
        n = 0;
        #1;
        while (s3 && n < 20) begin
            if (n > 0) chk({tag, " bubble"}, 32'(v3), 32'd0);
            tick();
            n++;
        end
        chk({tag, " stalls"}, n, 32'd3);
        tick();
    endtask

    initial begin
        #1 rst = 1'b0;
        #10;
        chk("rst stall0", 32'(s0), 32'd0);
        chk("rst stall3", 32'(s3), 32'd0);
        chk("rst valid", 32'(v0), 32'd0);
        chk("rst rdata", rdat0, 32'd0);
        chk("rst pc4", pc3, 32'd0);
        rst = 1'b1;
        tick();

        op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
        #1;
        chk("sw stall", 32'(s0), 32'd0);
        tick();
        chk("sw valid", 32'(v0), 32'd1);
        chk("sw regw", 32'(rw0), 32'd0);

        ld0("lw", 3'b010, 32'h10, 32'hDEADBEEF);
        chk("lw regw", 32'(rw0), 32'd1);
        chk("lw rd", 32'(rdw0), 32'd5);
        chk("lw rsrc", 32'(rs0), 32'd1);
        chk("lw pc4", pc0, 32'h1010);
        ld0("lb", 3'b000, 32'h13, 32'hFFFFFFDE);
        ld0("lbu", 3'b100, 32'h13, 32'h000000DE);
        ld0("lh", 3'b001, 32'h12, 32'hFFFFDEAD);
        ld0("lhu", 3'b101, 32'h10, 32'h0000BEEF);

        st0(3'b000, 32'h11, 32'h00000055);
        ld0("sb lw", 3'b010, 32'h10, 32'hDEAD55EF);
        st0(3'b001, 32'h12, 32'hAAAA1234);
        ld0("sh lw", 3'b010, 32'h10, 32'h123455EF);
        ld0("wrap lw", 3'b010, 32'h50, 32'h123455EF);

        op(1'b1, 1'b0, 3'b001, 32'h01, 32'd0, 5'd6);
        tick();
        chk("lh mis fault", 32'(f0), 32'd1);
        chk("lh mis regw", 32'(rw0), 32'd0);
        chk("lh mis valid", 32'(v0), 32'd1);
        chk("lh mis data", rdat0, 32'd0);
        st0(3'b010, 32'h20, 32'hCAFEF00D);
        chk("sw ok fault", 32'(f0), 32'd0);
        st0(3'b010, 32'h22, 32'h12345678);
        chk("sw mis fault", 32'(f0), 32'd1);
        ld0("sw mis mem", 3'b010, 32'h20, 32'hCAFEF00D);
        op(1'b1, 1'b0, 3'b011, 32'h10, 32'd0, 5'd7);
        tick();
        chk("f3 011 fault", 32'(f0), 32'd1);
        chk("f3 011 regw", 32'(rw0), 32'd0);

        op(1'b0, 1'b0, 3'b000, 32'h77, 32'd0, 5'd3);
        reg_write_m = 1'b1;
        tick();
        chk("alu valid", 32'(v0), 32'd1);
        chk("alu regw", 32'(rw0), 32'd1);
        chk("alu res", alu0, 32'h77);
        valid_m = 1'b0;
        tick();
        chk("bubble valid", 32'(v0), 32'd0);
        chk("bubble regw", 32'(rw0), 32'd0);

        idle();
        tick();
        rst = 1'b0;
        #2 rst = 1'b1;

        op(1'b0, 1'b1, 3'b010, 32'h30, 32'h11223344, 5'd0);
        wait3("ws sw");
        chk("ws sw valid", 32'(v3), 32'd1);
        op(1'b0, 1'b0, 3'b000, 32'h77, 32'd0, 5'd3);
        reg_write_m = 1'b1;
        #1;
        chk("ws alu stall", 32'(s3), 32'd0);
        tick();
        chk("ws alu valid", 32'(v3), 32'd1);
        chk("ws alu res", alu3, 32'h77);
        op(1'b1, 1'b0, 3'b010, 32'h30, 32'd0, 5'd7);
        wait3("ws lw");
        chk("ws lw data", rdat3, 32'h11223344);
        chk("ws lw regw", 32'(rw3), 32'd1);
        chk("ws lw rd", 32'(rdw3), 32'd7);

        op(1'b0, 1'b1, 3'b010, 32'h30, 32'h99999999, 5'd0);
        #1;
        chk("rw idle stall", 32'(s3), 32'd1);
        tick();
        chk("rw wait stall", 32'(s3), 32'd1);
        rst = 1'b0;
        #1;
        chk("rw stall", 32'(s3), 32'd0);
        chk("rw valid", 32'(v3), 32'd0);
        chk("rw rdata", rdat3, 32'd0);
        chk("rw alu", alu3, 32'd0);
        chk("rw pc4", pc3, 32'd0);
        chk("rw rd", 32'(rdw3), 32'd0);
        idle();
        tick();
        tick();
        rst = 1'b1;
        op(1'b1, 1'b0, 3'b010, 32'h30, 32'd0, 5'd8);
        wait3("rw lw");
        chk("rw lw data", rdat3, 32'h11223344);

        op(1'b1, 1'b0, 3'b001, 32'h31, 32'd0, 5'd9);
        wait3("ws fault");
        chk("ws fault", 32'(f3w), 32'd1);
        chk("ws fault regw", 32'(rw3), 32'd0);
        chk("ws fault valid", 32'(v3), 32'd1);

        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
